alu_arbiter: RTL and testbench

Round-robin arbiter and two-stage sequencer that shares the single 64-bit `alu` instance between NREQ requesters. It accepts one operation per cycle over valid/ready, registers operands, evaluates them on the shared `alu`, and registers result, flags and requester ID. Results are returned in acceptance order on one response channel with backpressure. The block sits between the decode/issue logic and the shared ALU.

---
 rtl/alu_arb_pkg.sv | 30 +++
 rtl/alu.sv | 51 +++++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/alu_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and op helpers for the ALU arbiter slice.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package alu_arb_pkg;

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry_out;
    } alu_flags_t;

    // Only add/sub produce meaningful overflow and carry.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // 001 and 111 are unassigned encodings.
    function automatic logic is_legal(input logic [2:0] op);
        return (op != 3'b001) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/alu.sv
// Shared 64-bit combinational ALU: pass B, add, sub, and, or, xor, with NZVC flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when to capture the outputs.
module alu
    import alu_arb_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] result_o,
    output alu_flags_t  flags_o
);

    logic [64:0] add_w;
    logic [64:0] sub_w;
    logic        ovf;
    logic        cry;

    // Subtract as A + ~B + 1 so carry_out means "no borrow" (A >= B unsigned).
    assign add_w = {1'b0, a_i} + {1'b0, b_i};
    assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + 65'd1;

    // Result select plus flag generation; N and Z derive from the selected result.
    always_comb begin
        result_o = '0;
        ovf      = 1'b0;
        cry      = 1'b0;
        case (op_i)
            OP_PASSB: result_o = b_i;
            OP_ADD: begin
                result_o = add_w[63:0];
                cry      = add_w[64];
                ovf      = (a_i[63] == b_i[63]) && (add_w[63] != a_i[63]);
            end
            OP_SUB: begin
                result_o = sub_w[63:0];
                cry      = sub_w[64];
                ovf      = (a_i[63] != b_i[63]) && (sub_w[63] != a_i[63]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
        flags_o.negative  = result_o[63];
        flags_o.zero      = (result_o == 64'd0);
        flags_o.overflow  = ovf;
        flags_o.carry_out = cry;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last-granted index.
// Latency: grant is combinational from req/en; pointer moves on the edge when advance is high.
// Backpressure: en low suppresses every grant; pointer holds until a grant is taken.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    logic           found;

    // Scan NREQ positions starting at ptr+1 (wrapping); first requester wins.
    always_comb begin
        gnt_o   = '0;
        win_idx = ptr_q;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (en_i && found) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    // The winner becomes the new lowest priority only when its grant was used.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = win_idx;
        end
    end

    // Pointer register; reset to NREQ-1 so requester 0 is searched first.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= IDW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 64-bit ALU among NREQ requesters: RR grant -> S1 operand reg -> ALU -> S2 result reg.
// Latency: transfer at edge t gives rsp_valid after edge t+1; 1 op/cycle with rsp_ready high.
// Backpressure: S2 holds while rsp_ready=0, S1 takes one more op, then req_ready stays 0. Option: ALU_ARB_ILLEGAL_CHK_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][2:0]  req_op,
    input  logic [NREQ-1:0][63:0] req_a,
    input  logic [NREQ-1:0][63:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [63:0]           rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  rsp_err
);

    // Stage 1: operand register
    logic            s1_vld_q, s1_vld_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic [2:0]      s1_op_q, s1_op_d;
    logic [63:0]     s1_a_q, s1_a_d;
    logic [63:0]     s1_b_q, s1_b_d;

    // Stage 2: output register
    logic            s2_vld_q, s2_vld_d;
    logic [IDW-1:0]  s2_id_q, s2_id_d;
    logic [63:0]     s2_res_q, s2_res_d;
    alu_flags_t      s2_flags_q, s2_flags_d;
    logic            s2_err_q, s2_err_d;

    logic            s2_drain;
    logic            s2_load;
    logic            s1_free;
    logic            arb_en;
    logic            xfer;
    logic [NREQ-1:0] gnt;

    logic [IDW-1:0]  sel_id;
    logic [2:0]      sel_op;
    logic [63:0]     sel_a;
    logic [63:0]     sel_b;

    logic [2:0]      alu_op;
    logic [63:0]     alu_res;
    alu_flags_t      alu_flags;
    logic            s1_err;

    // Pipeline advance conditions: S2 empties on handshake, S1 moves whenever S2 has room.
    assign s2_drain = s2_vld_q && rsp_ready;
    assign s2_load  = s1_vld_q && (!s2_vld_q || s2_drain);
    assign s1_free  = !s1_vld_q || s2_load;
    assign arb_en   = s1_free && !reset;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk_i     (clk),
        .reset_i   (reset),
        .req_i     (req_valid),
        .en_i      (arb_en),
        .advance_i (xfer),
        .gnt_o     (gnt)
    );

    // The arbiter only grants active requesters, so any grant is a transfer.
    assign req_ready = gnt;
    assign xfer      = |gnt;

    // One-hot payload mux driven by the grant.
    always_comb begin
        sel_id = '0;
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_id = IDW'(i);
                sel_op = req_op[i];
                sel_a  = req_a[i];
                sel_b  = req_b[i];
            end
        end
    end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    // Illegal encodings run as pass-B and are reported with a zeroed result.
    assign s1_err = !is_legal(s1_op_q);
    assign alu_op = s1_err ? OP_PASSB : s1_op_q;
`else
    assign s1_err = 1'b0;
    assign alu_op = s1_op_q;
`endif

    alu u_alu (
        .op_i     (alu_op),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    // S1 next state: load on transfer, otherwise empty out when S1 moves to S2.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_id_d  = s1_id_q;
        s1_op_d  = s1_op_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        if (xfer) begin
            s1_vld_d = 1'b1;
            s1_id_d  = sel_id;
            s1_op_d  = sel_op;
            s1_a_d   = sel_a;
            s1_b_d   = sel_b;
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end
    end

    // S2 next state: capture ALU output with V/C masked for non-arith ops.
    always_comb begin
        s2_vld_d   = s2_vld_q;
        s2_id_d    = s2_id_q;
        s2_res_d   = s2_res_q;
        s2_flags_d = s2_flags_q;
        s2_err_d   = s2_err_q;
        if (s2_load) begin
            s2_vld_d   = 1'b1;
            s2_id_d    = s1_id_q;
            s2_res_d   = s1_err ? 64'd0 : alu_res;
            s2_flags_d = alu_flags;
            if (!is_arith(s1_op_q)) begin
                s2_flags_d.overflow  = 1'b0;
                s2_flags_d.carry_out = 1'b0;
            end
            if (s1_err) begin
                s2_flags_d = '0;
            end
            s2_err_d   = s1_err;
        end else if (s2_drain) begin
            s2_vld_d = 1'b0;
        end
    end

    // S1 register; reset discards any in-flight operand.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_id_q  <= '0;
            s1_op_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            s1_op_q  <= s1_op_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
        end
    end

    // S2 register; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld_q   <= 1'b0;
            s2_id_q    <= '0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s2_vld_q   <= s2_vld_d;
            s2_id_q    <= s2_id_d;
            s2_res_q   <= s2_res_d;
            s2_flags_q <= s2_flags_d;
            s2_err_q   <= s2_err_d;
        end
    end

    // Response outputs read as zero for the whole time reset is high.
    assign rsp_valid  = s2_vld_q && !reset;
    assign rsp_id     = reset ? '0 : s2_id_q;
    assign rsp_result = reset ? '0 : s2_res_q;
    assign rsp_flags  = reset ? '0 : s2_flags_q;
    assign rsp_err    = reset ? 1'b0 : s2_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed test-plan steps then random traffic against a queue-based model.
// Latency: model treats an op accepted at edge t as visible after edge t+1, drained in order.
// Backpressure: model admits a new op only while fewer than two are held or the head drains.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][2:0]  req_op;
    logic [NREQ-1:0][63:0] req_a;
    logic [NREQ-1:0][63:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [63:0]           rsp_result;
    logic [3:0]            rsp_flags;
    logic                  rsp_err;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] res;
        logic [3:0]  flags;
        logic        err;
        bit          dchk;
        int          t;
    } item_t;

    item_t       q[$];
    int          mptr = NREQ - 1;
    int          cyc  = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_xfer = 0;
    int          n_rsp = 0;
    logic [NREQ-1:0] last_gnt;
    logic [NREQ-1:0] prev_gnt;

    bit          pv  [NREQ];
    logic [2:0]  pop [NREQ];
    logic [63:0] pa  [NREQ];
    logic [63:0] pb  [NREQ];
    bit          rst_drv = 1'b1;
    bit          rdy_drv = 1'b1;
    int          fill_pct = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference ALU straight from the op definitions, using wide signed sums for overflow.
    function automatic void ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic [3:0] f,
                                    output logic e, output bit dchk);
        logic signed [64:0] s;
        logic v, c;
        bit   illegal;
        v = 1'b0; c = 1'b0; e = 1'b0; dchk = 1'b1; r = '0; illegal = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                s = $signed({a[63], a}) + $signed({b[63], b});
                v = (s[64] != s[63]);
            end
            3'b011: begin
                r = a - b;
                c = (a >= b);
                s = $signed({a[63], a}) - $signed({b[63], b});
                v = (s[64] != s[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: illegal = 1'b1;
        endcase
        f = {r[63], (r == 64'd0), v, c};
        if (illegal) begin
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            e = 1'b1; r = '0; f = '0;
`else
            dchk = 1'b0;
`endif
        end
    endfunction

    function automatic logic [2:0] rand_op();
        logic [2:0] o;
        o = 3'($urandom_range(7));
`ifndef ALU_ARB_ILLEGAL_CHK_EN
        if (o == 3'b001) o = 3'b010;
        if (o == 3'b111) o = 3'b011;
`endif
        return o;
    endfunction

    function automatic logic [63:0] rand_val();
        case ($urandom_range(7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One clock: drive at the low phase, check #1 later, advance the model at the rising edge.
    task automatic step();
        logic [NREQ-1:0] eg;
        logic            ev;
        int              g;
        item_t           it;
        for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && fill_pct > 0 && int'($urandom_range(99)) < fill_pct) begin
                pv[i] = 1'b1; pop[i] = rand_op(); pa[i] = rand_val(); pb[i] = rand_val();
            end
        end
        reset     = rst_drv;
        rsp_ready = rdy_drv;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pv[i]; req_op[i] = pop[i]; req_a[i] = pa[i]; req_b[i] = pb[i];
        end
        #1;
        ev = !rst_drv && (q.size() > 0) && (cyc >= q[0].t + 1);
        eg = '0;
        g  = -1;
        if (!rst_drv && (q.size() < 2 || (ev && rdy_drv))) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (mptr + k) % NREQ;
                if (g < 0 && pv[c]) g = c;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", req_ready, eg);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_err", rsp_err, q[0].err);
            if (q[0].dchk) begin
                chk("rsp_result", rsp_result, q[0].res);
                chk("rsp_flags", rsp_flags, q[0].flags);
            end
        end
        if (rst_drv) chk("rst_rsp_zero", {rsp_id, rsp_result, rsp_flags, rsp_err}, '0);
        last_gnt = req_ready;
        n_xfer  += int'(|(req_valid & req_ready));
        n_rsp   += int'(rsp_valid && rsp_ready);
        @(posedge clk);
        cyc++;
        if (rst_drv) begin
            q.delete();
            mptr = NREQ - 1;
        end else begin
            if (ev && rdy_drv) void'(q.pop_front());
            if (g >= 0) begin
                ref_alu(pop[g], pa[g], pb[g], it.res, it.flags, it.err, it.dchk);
                it.id = g;
                it.t  = cyc;
                q.push_back(it);
                mptr  = g;
                pv[g] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send0(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        pv[0] = 1'b1; pop[0] = op; pa[0] = a; pb[0] = b;
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b0; pop[i] = '0; pa[i] = '0; pb[i] = '0;
        end

        // Reset state
        rst_drv = 1'b1; rdy_drv = 1'b1; fill_pct = 0;
        step(); step();
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        rst_drv = 1'b0;

        // Single add: 5 + 3 from requester 0
        send0(3'b010, 64'd5, 64'd3);
        chk("add_valid", rsp_valid, 1'b1);
        chk("add_result", rsp_result, 64'd8);
        chk("add_id", rsp_id, 1'b0);
        chk("add_flags", rsp_flags, 4'b0000);
        chk("add_err", rsp_err, 1'b0);

        // Subtract producing a negative value, then an exact zero
        send0(3'b011, 64'd3, 64'd5);
        chk("sub_neg_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_neg_flags", rsp_flags, 4'b1000);
        send0(3'b011, 64'd5, 64'd5);
        chk("sub_zero_result", rsp_result, 64'd0);
        chk("sub_zero_flags", rsp_flags, 4'b0101);

        // Flag masking on the same operands: add overflows, AND must not report V/C
        send0(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("mask_add_result", rsp_result, 64'h8000_0000_0000_0000);
        chk("mask_add_flags", rsp_flags, 4'b1010);
        send0(3'b100, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("mask_and_result", rsp_result, 64'd1);
        chk("mask_and_flags", rsp_flags, 4'b0000);

`ifdef ALU_ARB_ILLEGAL_CHK_EN
        // Illegal op is accepted and flagged
        send0(3'b111, 64'h1234, 64'h5678);
        chk("illegal_err", rsp_err, 1'b1);
        chk("illegal_result", rsp_result, 64'd0);
        chk("illegal_flags", rsp_flags, 4'b0000);
`endif

        // Fairness: both requesters always valid, grants must alternate
        fill_pct = 100; rdy_drv = 1'b1;
        prev_gnt = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("fair_granted", |last_gnt, 1'b1);
            if (k > 0) chk("fair_alternate", last_gnt != prev_gnt, 1'b1);
            prev_gnt = last_gnt;
        end

        // Drain, then backpressure for 5 cycles
        fill_pct = 0;
        for (int k = 0; k < 4; k++) step();
        n_xfer = 0; n_rsp = 0;
        fill_pct = 100; rdy_drv = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("bp_transfers", n_xfer, 2);
        chk("bp_ready_low", last_gnt, '0);
        chk("bp_hold_valid", rsp_valid, 1'b1);
        fill_pct = 0; rdy_drv = 1'b1;
        for (int k = 0; k < 8; k++) step();
        chk("bp_responses", n_rsp, 4);
        chk("bp_drained", rsp_valid, 1'b0);

        // Reset with both stages full, then first grant must go to requester 0
        fill_pct = 100; rdy_drv = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("full_before_reset", rsp_valid, 1'b1);
        fill_pct = 0; rst_drv = 1'b1;
        step();
        chk("reset_flush", rsp_valid, 1'b0);
        rst_drv = 1'b0; rdy_drv = 1'b1;
        pv[0] = 1'b1; pv[1] = 1'b1;
        step();
        chk("post_reset_grant", last_gnt, 2'b01);

        // Random traffic
        fill_pct = 60;
        for (int k = 0; k < 400; k++) begin
            rdy_drv = (int'($urandom_range(99)) < 70);
            step();
        end
        fill_pct = 0; rdy_drv = 1'b1;
        for (int k = 0; k < 8; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
